// File: rtl/ac_motor_gate_pkg.sv
// Shared types and default widths for the three-phase gate-bus monitor.
// Phase states are encoded as their {g_high, g_low} input pattern.
package ac_motor_gate_pkg;

  localparam int CNT_W_DEF   = 15;
  localparam int DELAY_W_DEF = 12;

  typedef enum logic [1:0] {
    PH_DEAD  = 2'b00,
    PH_LOW   = 2'b01,
    PH_HIGH  = 2'b10,
    PH_SHOOT = 2'b11
  } phase_state_e;

  function automatic phase_state_e decode_phase(input logic g_high, input logic g_low);
    phase_state_e st;
    case ({g_high, g_low})
      2'b01:   st = PH_LOW;
      2'b10:   st = PH_HIGH;
      2'b11:   st = PH_SHOOT;
      default: st = PH_DEAD;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/ac_motor_gate_phase.sv
// Per-phase gate checker: state tracking, dead-time and on-time counters,
// sticky shoot-through / dead-time flags and the on-time update pulse.
module ac_motor_gate_phase
  import ac_motor_gate_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DELAY_W = DELAY_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DELAY_W-1:0] min_delay,
  input  logic               clear_fault,
  input  logic               g_high,
  input  logic               g_low,
  output logic               vector_bit,
  output logic               driven,
  output logic [CNT_W-1:0]   on_time,
  output logic               on_valid,
  output logic               fault_shoot,
  output logic               fault_dead
);

  phase_state_e       state;
  phase_state_e       next_state;
  logic [DELAY_W-1:0] dead_cnt;
  logic [CNT_W-1:0]   on_cnt;
  logic [DELAY_W-1:0] observed_dead;
  logic               entering;
  logic               dead_viol;
  logic               shoot_viol;
  logic               leave_high;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    next_state    = decode_phase(g_high, g_low);
    entering      = (next_state != state);
    observed_dead = (state == PH_DEAD) ? dead_cnt : '0;
    dead_viol     = 1'b0;
    if (entering && (next_state == PH_HIGH || next_state == PH_LOW))
      dead_viol = (observed_dead < min_delay);
    shoot_viol    = entering && (next_state == PH_SHOOT);
    leave_high    = (state == PH_HIGH) && (next_state != PH_HIGH);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PH_DEAD;
      dead_cnt    <= '1;  // saturated so the first turn-on after reset is legal
      on_cnt      <= '0;
      on_time     <= '0;
      on_valid    <= 1'b0;
      vector_bit  <= 1'b0;
      driven      <= 1'b0;
      fault_shoot <= 1'b0;
      fault_dead  <= 1'b0;
    end else begin
      state    <= next_state;
      driven   <= (next_state == PH_HIGH) || (next_state == PH_LOW);
      on_valid <= leave_high;

      // The entry cycle counts as one cycle in the state, so the value seen
      // at exit equals the number of cycles the pattern was present.
      if (next_state == PH_DEAD) begin
        if (state != PH_DEAD)
          dead_cnt <= DELAY_W'(1);
        else if (dead_cnt != '1)
          dead_cnt <= dead_cnt + 1'b1;
      end

      if (next_state == PH_HIGH) begin
        if (state != PH_HIGH)
          on_cnt <= CNT_W'(1);
        else if (on_cnt != '1)
          on_cnt <= on_cnt + 1'b1;
      end

      if (leave_high)
        on_time <= on_cnt;

      if (next_state == PH_HIGH)
        vector_bit <= 1'b1;
      else if (next_state == PH_LOW)
        vector_bit <= 1'b0;

      // A new violation wins over a simultaneous clear.
      if (shoot_viol)
        fault_shoot <= 1'b1;
      else if (clear_fault)
        fault_shoot <= 1'b0;

      if (dead_viol)
        fault_dead <= 1'b1;
      else if (clear_fault)
        fault_dead <= 1'b0;
    end
  end

endmodule

// File: rtl/ac_motor_gate_monitor.sv
// Gate-bus monitor top: input capture, three phase checkers, vector assembly.
// Define AC_MOTOR_GATE_SYNC_EN to add a two-flop synchroniser on the gate inputs.
module ac_motor_gate_monitor
  import ac_motor_gate_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DELAY_W = DELAY_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DELAY_W-1:0] min_delay,
  input  logic               clear_fault,
  input  logic [2:0]         g_high,
  input  logic [2:0]         g_low,
  output logic [2:0]         vector,
  output logic               vector_valid,
  output logic [CNT_W-1:0]   on_time_0,
  output logic [CNT_W-1:0]   on_time_1,
  output logic [CNT_W-1:0]   on_time_2,
  output logic [2:0]         on_valid,
  output logic [2:0]         fault_shoot,
  output logic [2:0]         fault_dead,
  output logic               fault
);

  logic [2:0]       g_high_in;
  logic [2:0]       g_low_in;
  logic [2:0]       g_high_q;
  logic [2:0]       g_low_q;
  logic [2:0]       driven;
  logic [CNT_W-1:0] on_time_a [3];

`ifdef AC_MOTOR_GATE_SYNC_EN
  logic [5:0] sync_ff1;
  logic [5:0] sync_ff2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff1 <= '0;
      sync_ff2 <= '0;
    end else begin
      sync_ff1 <= {g_high, g_low};
      sync_ff2 <= sync_ff1;
    end
  end

  assign {g_high_in, g_low_in} = sync_ff2;
`else
  assign g_high_in = g_high;
  assign g_low_in  = g_low;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_high_q <= '0;
      g_low_q  <= '0;
    end else begin
      g_high_q <= g_high_in;
      g_low_q  <= g_low_in;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_phase
    ac_motor_gate_phase #(
      .CNT_W   (CNT_W),
      .DELAY_W (DELAY_W)
    ) u_phase (
      .clk         (clk),
      .rst_n       (rst_n),
      .min_delay   (min_delay),
      .clear_fault (clear_fault),
      .g_high      (g_high_q[i]),
      .g_low       (g_low_q[i]),
      .vector_bit  (vector[i]),
      .driven      (driven[i]),
      .on_time     (on_time_a[i]),
      .on_valid    (on_valid[i]),
      .fault_shoot (fault_shoot[i]),
      .fault_dead  (fault_dead[i])
    );
  end

  assign on_time_0    = on_time_a[0];
  assign on_time_1    = on_time_a[1];
  assign on_time_2    = on_time_a[2];
  assign vector_valid = &driven;
  assign fault        = (|fault_shoot) | (|fault_dead);

endmodule

// File: tb/tb_ac_motor_gate_monitor.sv
// Directed self-checking bench for ac_motor_gate_monitor (default build).
// A vector table covers the main paths; hand sequences cover multi-cycle corners.
module tb_ac_motor_gate_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] min_delay;
  logic        clear_fault;
  logic [2:0]  g_high;
  logic [2:0]  g_low;
  logic [2:0]  vector;
  logic        vector_valid;
  logic [14:0] on_time_0, on_time_1, on_time_2;
  logic [2:0]  on_valid;
  logic [2:0]  fault_shoot;
  logic [2:0]  fault_dead;
  logic        fault;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ac_motor_gate_monitor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .min_delay    (min_delay),
    .clear_fault  (clear_fault),
    .g_high       (g_high),
    .g_low        (g_low),
    .vector       (vector),
    .vector_valid (vector_valid),
    .on_time_0    (on_time_0),
    .on_time_1    (on_time_1),
    .on_time_2    (on_time_2),
    .on_valid     (on_valid),
    .fault_shoot  (fault_shoot),
    .fault_dead   (fault_dead),
    .fault        (fault)
  );

  typedef struct {
    logic [2:0]  gh;
    logic [2:0]  gl;
    logic [11:0] md;
    logic        clr;
    int          hold;
    logic [2:0]  vec;
    logic        vv;
    logic [2:0]  fs;
    logic [2:0]  fd;
    logic [14:0] on0;
    logic [14:0] on1;
    logic [14:0] on2;
  } row_t;

  row_t rows [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] gh, input logic [2:0] gl);
    g_high = gh;
    g_low  = gl;
  endtask

  initial begin
    //           gh      gl      md     clr   hold vec     vv    fs      fd      on0    on1     on2
    rows[0]  = '{3'b000, 3'b000, 12'd4, 1'b0, 2,  3'b000, 1'b0, 3'b000, 3'b000, 15'd0, 15'd0,  15'd0};
    rows[1]  = '{3'b001, 3'b000, 12'd4, 1'b0, 2,  3'b001, 1'b0, 3'b000, 3'b000, 15'd0, 15'd0,  15'd0};
    rows[2]  = '{3'b001, 3'b110, 12'd4, 1'b0, 2,  3'b001, 1'b1, 3'b000, 3'b000, 15'd0, 15'd0,  15'd0};
    rows[3]  = '{3'b001, 3'b100, 12'd4, 1'b0, 4,  3'b001, 1'b0, 3'b000, 3'b000, 15'd0, 15'd0,  15'd0};
    rows[4]  = '{3'b011, 3'b100, 12'd4, 1'b0, 10, 3'b011, 1'b1, 3'b000, 3'b000, 15'd0, 15'd0,  15'd0};
    rows[5]  = '{3'b001, 3'b100, 12'd4, 1'b0, 4,  3'b011, 1'b0, 3'b000, 3'b000, 15'd0, 15'd10, 15'd0};
    rows[6]  = '{3'b001, 3'b110, 12'd4, 1'b0, 2,  3'b001, 1'b1, 3'b000, 3'b000, 15'd0, 15'd10, 15'd0};
    rows[7]  = '{3'b001, 3'b100, 12'd4, 1'b0, 4,  3'b001, 1'b0, 3'b000, 3'b000, 15'd0, 15'd10, 15'd0};
    rows[8]  = '{3'b011, 3'b100, 12'd4, 1'b0, 6,  3'b011, 1'b1, 3'b000, 3'b000, 15'd0, 15'd10, 15'd0};
    rows[9]  = '{3'b001, 3'b100, 12'd4, 1'b0, 3,  3'b011, 1'b0, 3'b000, 3'b000, 15'd0, 15'd6,  15'd0};
    rows[10] = '{3'b001, 3'b110, 12'd4, 1'b0, 2,  3'b001, 1'b1, 3'b000, 3'b010, 15'd0, 15'd6,  15'd0};
    rows[11] = '{3'b001, 3'b010, 12'd4, 1'b0, 4,  3'b001, 1'b0, 3'b000, 3'b010, 15'd0, 15'd6,  15'd0};
    rows[12] = '{3'b101, 3'b010, 12'd4, 1'b0, 5,  3'b101, 1'b1, 3'b000, 3'b010, 15'd0, 15'd6,  15'd0};
    rows[13] = '{3'b001, 3'b110, 12'd1, 1'b0, 2,  3'b001, 1'b1, 3'b000, 3'b110, 15'd0, 15'd6,  15'd5};
    rows[14] = '{3'b001, 3'b110, 12'd1, 1'b1, 1,  3'b001, 1'b1, 3'b000, 3'b000, 15'd0, 15'd6,  15'd5};
    rows[15] = '{3'b101, 3'b010, 12'd0, 1'b0, 3,  3'b101, 1'b1, 3'b000, 3'b000, 15'd0, 15'd6,  15'd5};
    rows[16] = '{3'b001, 3'b110, 12'd0, 1'b0, 3,  3'b001, 1'b1, 3'b000, 3'b000, 15'd0, 15'd6,  15'd3};

    rst_n       = 1'b0;
    min_delay   = 12'd4;
    clear_fault = 1'b0;
    drive(3'b000, 3'b000);
    #1;
    check("reset vector", 32'(vector), 32'd0);
    check("reset on_valid", 32'(on_valid), 32'd0);
    check("reset fault", 32'(fault), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);

    for (int i = 0; i < 17; i++) begin
      drive(rows[i].gh, rows[i].gl);
      min_delay   = rows[i].md;
      clear_fault = rows[i].clr;
      step(rows[i].hold);
      check($sformatf("row%0d vector", i), 32'(vector), 32'(rows[i].vec));
      check($sformatf("row%0d vector_valid", i), 32'(vector_valid), 32'(rows[i].vv));
      check($sformatf("row%0d fault_shoot", i), 32'(fault_shoot), 32'(rows[i].fs));
      check($sformatf("row%0d fault_dead", i), 32'(fault_dead), 32'(rows[i].fd));
      check($sformatf("row%0d fault", i), 32'(fault), 32'((|rows[i].fs) | (|rows[i].fd)));
      check($sformatf("row%0d on_time_0", i), 32'(on_time_0), 32'(rows[i].on0));
      check($sformatf("row%0d on_time_1", i), 32'(on_time_1), 32'(rows[i].on1));
      check($sformatf("row%0d on_time_2", i), 32'(on_time_2), 32'(rows[i].on2));
    end
    clear_fault = 1'b0;
    min_delay   = 12'd4;

    // Shoot-through on phase 0 out of a 7-cycle HIGH, then straight to LOW.
    drive(3'b000, 3'b110);
    step(4);
    drive(3'b001, 3'b110);
    step(7);
    drive(3'b001, 3'b111);
    step(1);
    drive(3'b000, 3'b111);
    step(1);
    check("shoot fault_shoot", 32'(fault_shoot), 32'b001);
    check("shoot vector hold", 32'(vector), 32'b001);
    check("shoot vector_valid", 32'(vector_valid), 32'd0);
    check("shoot on_valid", 32'(on_valid), 32'b001);
    check("shoot on_time_0", 32'(on_time_0), 32'd7);
    step(1);
    check("post-shoot fault_dead", 32'(fault_dead), 32'b001);
    check("post-shoot vector", 32'(vector), 32'b000);
    check("post-shoot on_valid", 32'(on_valid), 32'd0);
    check("post-shoot fault", 32'(fault), 32'd1);

    // Clear with no activity.
    clear_fault = 1'b1;
    step(1);
    clear_fault = 1'b0;
    check("clear fault_shoot", 32'(fault_shoot), 32'd0);
    check("clear fault_dead", 32'(fault_dead), 32'd0);
    check("clear fault", 32'(fault), 32'd0);

    // Clear in the same cycle as a direct LOW->HIGH on phase 1: set wins.
    drive(3'b010, 3'b101);
    step(1);
    clear_fault = 1'b1;
    step(1);
    clear_fault = 1'b0;
    check("clear+set fault_dead", 32'(fault_dead), 32'b010);
    check("clear+set fault", 32'(fault), 32'd1);

    // Phase 1 leaves a 2-cycle HIGH: single-cycle on_valid pulse.
    drive(3'b000, 3'b101);
    step(1);
    check("pre-exit on_valid", 32'(on_valid), 32'd0);
    step(1);
    check("exit on_valid", 32'(on_valid), 32'b010);
    check("exit on_time_1", 32'(on_time_1), 32'd2);
    step(1);
    check("pulse width on_valid", 32'(on_valid), 32'd0);

    // PWM periods with 4-cycle dead time on every edge.
    clear_fault = 1'b1;
    step(1);
    clear_fault = 1'b0;
    for (int p = 0; p < 3; p++) begin
      drive(3'b000, 3'b000);
      step(4);
      drive(3'b111, 3'b000);
      step(100);
      drive(3'b000, 3'b000);
      step(4);
      drive(3'b000, 3'b111);
      step(50);
      check($sformatf("pwm%0d on_time_0", p), 32'(on_time_0), 32'd100);
      check($sformatf("pwm%0d on_time_1", p), 32'(on_time_1), 32'd100);
      check($sformatf("pwm%0d on_time_2", p), 32'(on_time_2), 32'd100);
      check($sformatf("pwm%0d fault", p), 32'(fault), 32'd0);
      check($sformatf("pwm%0d vector", p), 32'(vector), 32'd0);
      check($sformatf("pwm%0d vector_valid", p), 32'(vector_valid), 32'd1);
    end

    // On-time saturation on phase 0.
    drive(3'b000, 3'b000);
    step(4);
    drive(3'b001, 3'b000);
    step(33000);
    drive(3'b000, 3'b000);
    step(4);
    check("sat on_time_0", 32'(on_time_0), 32'd32767);
    check("sat fault", 32'(fault), 32'd0);

    // Reset in the middle of a HIGH interval discards the partial count.
    drive(3'b001, 3'b000);
    step(10);
    rst_n = 1'b0;
    #1;
    check("midreset on_time_0", 32'(on_time_0), 32'd0);
    check("midreset on_valid", 32'(on_valid), 32'd0);
    check("midreset vector", 32'(vector), 32'd0);
    drive(3'b000, 3'b000);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(1);
      check($sformatf("postreset%0d on_valid", c), 32'(on_valid), 32'd0);
    end
    check("postreset on_time_0", 32'(on_time_0), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
